servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pwm_multi.sv | 197 +++++++++++++++++++
 tb/tb_servo_pwm_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: one shared period counter, per-channel MIN/MAX/WIDTH
// registers, fixed or sweep mode with endpoint flags, Avalon-MM register slave.
module servo_pwm_multi #(
  parameter int NUM_CH     = 4,
  parameter int PERIOD_CYC = 1000000,
  parameter int MIN_DEF    = 50000,
  parameter int MAX_DEF    = 100000,
  parameter int STEP       = 500,
  localparam int CNT_W     = $clog2(PERIOD_CYC),
  localparam int AW        = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);
  localparam int EW = CNT_W + 1;

  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              boundary_s;
  logic [CNT_W-1:0]  min_r [NUM_CH];
  logic [CNT_W-1:0]  min_s [NUM_CH];
  logic [CNT_W-1:0]  max_r [NUM_CH];
  logic [CNT_W-1:0]  max_s [NUM_CH];
  logic [CNT_W-1:0]  width_r [NUM_CH];
  logic [CNT_W-1:0]  width_s [NUM_CH];
  logic [CNT_W-1:0]  active_r [NUM_CH];
  logic [CNT_W-1:0]  active_s [NUM_CH];
  logic [EW-1:0]     up_s [NUM_CH];
  logic [EW-1:0]     lo_s [NUM_CH];
  logic [NUM_CH-1:0] en_r, en_s, sweep_r, sweep_s, dir_r, dir_s;
  logic [NUM_CH-1:0] flag_r, flag_s, hw_flag_s, wr_hit_s, pwm_r, pwm_s;
  logic              irq_r, irq_s;
  logic [31:0]       rdata_r, rdata_s;
  logic [1:0]        reg_sel_s;
  logic [31:0]       ch_sel_s;
  logic              ch_valid_s;
  logic              unused_wdata_s;

  assign reg_sel_s      = avs_address[1:0];
  assign ch_sel_s       = 32'(avs_address >> 2'd2);
  assign ch_valid_s     = (ch_sel_s < 32'(NUM_CH));
  assign unused_wdata_s = ^avs_writedata[31:CNT_W];

  assign pwm_out      = pwm_r;
  assign irq          = irq_r;
  assign avs_readdata = rdata_r;

  // Next-state logic: period counter, boundary update, bus writes, read mux.
  always_comb begin
    boundary_s = (cnt_r == CNT_W'(PERIOD_CYC - 1));
    if (boundary_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
    irq_s = |flag_r;

    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_s[i]  = avs_write && ch_valid_s && (ch_sel_s == 32'(i));
      min_s[i]     = min_r[i];
      max_s[i]     = max_r[i];
      width_s[i]   = width_r[i];
      active_s[i]  = active_r[i];
      en_s[i]      = en_r[i];
      sweep_s[i]   = sweep_r[i];
      dir_s[i]     = dir_r[i];
      flag_s[i]    = flag_r[i];
      hw_flag_s[i] = 1'b0;
      up_s[i]      = {1'b0, width_r[i]} + EW'(STEP);
      lo_s[i]      = {1'b0, min_r[i]} + EW'(STEP);

      if (en_r[i] && boundary_s) begin
        if (min_r[i] > max_r[i]) begin
          width_s[i] = min_r[i];
        end else if (!sweep_r[i]) begin
          if (width_r[i] < min_r[i]) begin
            width_s[i] = min_r[i];
          end else if (width_r[i] > max_r[i]) begin
            width_s[i] = max_r[i];
          end else begin
            width_s[i] = width_r[i];
          end
        end else if (!dir_r[i]) begin
          if (up_s[i] >= {1'b0, max_r[i]}) begin
            width_s[i]   = max_r[i];
            dir_s[i]     = 1'b1;
            hw_flag_s[i] = 1'b1;
          end else begin
            width_s[i] = up_s[i][CNT_W-1:0];
          end
        end else begin
          if ({1'b0, width_r[i]} <= lo_s[i]) begin
            width_s[i]   = min_r[i];
            dir_s[i]     = 1'b0;
            hw_flag_s[i] = 1'b1;
          end else begin
            width_s[i] = width_r[i] - CNT_W'(STEP);
          end
        end
      end else begin
        width_s[i] = width_r[i];
      end

      if (hw_flag_s[i]) begin
        flag_s[i] = 1'b1;
      end else begin
        flag_s[i] = flag_r[i];
      end

      // Bus writes override the boundary update; a hardware flag set beats a clear.
      if (wr_hit_s[i]) begin
        case (reg_sel_s)
          2'd0: min_s[i] = avs_writedata[CNT_W-1:0];
          2'd1: max_s[i] = avs_writedata[CNT_W-1:0];
          2'd2: begin
            en_s[i]    = avs_writedata[0];
            sweep_s[i] = avs_writedata[1];
            if (avs_writedata[3] && !hw_flag_s[i]) begin
              flag_s[i] = 1'b0;
            end else begin
              flag_s[i] = flag_s[i];
            end
          end
          2'd3: width_s[i] = avs_writedata[CNT_W-1:0];
          default: width_s[i] = width_s[i];
        endcase
      end else begin
        en_s[i] = en_r[i];
      end

      if (boundary_s) begin
        active_s[i] = width_s[i];
      end else begin
        active_s[i] = active_r[i];
      end
      pwm_s[i] = en_s[i] && (cnt_s < active_s[i]);
    end

    if (avs_read) begin
      rdata_s = 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid_s && (ch_sel_s == 32'(i))) begin
          case (reg_sel_s)
            2'd0:    rdata_s = 32'(min_r[i]);
            2'd1:    rdata_s = 32'(max_r[i]);
            2'd2:    rdata_s = {28'd0, flag_r[i], dir_r[i], sweep_r[i], en_r[i]};
            2'd3:    rdata_s = 32'(width_r[i]);
            default: rdata_s = 32'd0;
          endcase
        end else begin
          rdata_s = rdata_s;
        end
      end
    end else begin
      rdata_s = rdata_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      en_r    <= {NUM_CH{1'b0}};
      sweep_r <= {NUM_CH{1'b0}};
      dir_r   <= {NUM_CH{1'b0}};
      flag_r  <= {NUM_CH{1'b0}};
      pwm_r   <= {NUM_CH{1'b0}};
      irq_r   <= 1'b0;
      rdata_r <= 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        min_r[i]    <= CNT_W'(MIN_DEF);
        max_r[i]    <= CNT_W'(MAX_DEF);
        width_r[i]  <= CNT_W'(MIN_DEF);
        active_r[i] <= CNT_W'(MIN_DEF);
      end
    end else begin
      cnt_r    <= cnt_s;
      en_r     <= en_s;
      sweep_r  <= sweep_s;
      dir_r    <= dir_s;
      flag_r   <= flag_s;
      pwm_r    <= pwm_s;
      irq_r    <= irq_s;
      rdata_r  <= rdata_s;
      min_r    <= min_s;
      max_r    <= max_s;
      width_r  <= width_s;
      active_r <= active_s;
    end
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed self-checking bench for servo_pwm_multi (2 channels, 100-clock period,
// MIN 10, MAX 30, STEP 5).
module tb_servo_pwm_multi;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [1:0]  pwm_out;
  logic        irq;

  int tests = 0;
  int fails = 0;
  int mcnt  = 0;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH(2), .PERIOD_CYC(100), .MIN_DEF(10), .MAX_DEF(30), .STEP(5)
  ) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .pwm_out(pwm_out), .irq(irq)
  );

  // One clock: track the expected period position, sample after the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (reset) mcnt = 0;
    else if (mcnt == 99) mcnt = 0;
    else mcnt = mcnt + 1;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    cyc();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic goto(input int k);
    while (mcnt != k) cyc();
  endtask

  // Count high cycles of both channels over the next full period, optional write at cnt==at.
  task automatic measure(input bit do_wr, input int at, input logic [2:0] a,
                         input logic [31:0] d, output int w0, output int w1);
    goto(0);
    w0 = 0; w1 = 0;
    for (int i = 0; i < 100; i++) begin
      if (pwm_out[0]) w0++;
      if (pwm_out[1]) w1++;
      if (do_wr && i == at) begin
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
      end
      cyc();
      avs_write = 1'b0;
    end
  endtask

  int          w0, w1;
  logic [31:0] rv;
  int          exp_up [4] = '{15, 20, 25, 30};
  int          exp_dn [3] = '{20, 15, 10};

  initial begin
    reset = 1'b1; avs_address = 3'd0; avs_write = 1'b0; avs_writedata = 32'd0; avs_read = 1'b0;
    repeat (3) cyc();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    reset = 1'b0;
    rd(3'd0, rv); chk("rst_min0", rv, 32'd10);
    rd(3'd1, rv); chk("rst_max0", rv, 32'd30);
    rd(3'd3, rv); chk("rst_width0", rv, 32'd10);
    rd(3'd2, rv); chk("rst_ctrl0", rv, 32'd0);
    rd(3'd4, rv); chk("rst_min1", rv, 32'd10);

    // Fixed mode, default width
    wr(3'd2, 32'd1);
    measure(1'b0, 0, 3'd0, 32'd0, w0, w1);
    chk("en_w0", 32'(w0), 32'd10);
    chk("en_w1_idle", 32'(w1), 32'd0);
    rd(3'd2, rv); chk("en_ctrl0", rv, 32'd1);

    // Mid-period WIDTH write takes effect next period only
    measure(1'b1, 5, 3'd3, 32'd20, w0, w1); chk("midwr_cur", 32'(w0), 32'd10);
    measure(1'b0, 0, 3'd0, 32'd0, w0, w1);  chk("midwr_next", 32'(w0), 32'd20);
    rd(3'd3, rv); chk("midwr_width", rv, 32'd20);

    // Clamp above MAX, no flag
    measure(1'b1, 50, 3'd3, 32'd50, w0, w1); chk("clamp_cur", 32'(w0), 32'd20);
    measure(1'b0, 0, 3'd0, 32'd0, w0, w1);   chk("clamp_next", 32'(w0), 32'd30);
    rd(3'd3, rv); chk("clamp_width", rv, 32'd30);
    rd(3'd2, rv); chk("clamp_ctrl", rv, 32'd1);
    chk("clamp_irq", 32'(irq), 32'd0);

    // Sweep up from MIN to MAX
    wr(3'd3, 32'd10);
    wr(3'd2, 32'd3);
    for (int k = 0; k < 4; k++) begin
      measure(1'b0, 0, 3'd0, 32'd0, w0, w1);
      chk($sformatf("sweep_up%0d", k), 32'(w0), 32'(exp_up[k]));
    end
    rd(3'd2, rv); chk("top_ctrl", rv, 32'd15);
    chk("top_irq", 32'(irq), 32'd1);
    wr(3'd2, 32'h0000_000B);
    chk("clr_irq_lag", 32'(irq), 32'd1);
    cyc();
    chk("clr_irq_drop", 32'(irq), 32'd0);
    rd(3'd2, rv); chk("clr_ctrl", rv, 32'd7);

    // Sweep down to MIN
    for (int k = 0; k < 3; k++) begin
      measure(1'b0, 0, 3'd0, 32'd0, w0, w1);
      chk($sformatf("sweep_dn%0d", k), 32'(w0), 32'(exp_dn[k]));
    end
    rd(3'd2, rv); chk("bot_ctrl", rv, 32'd11);
    chk("bot_irq", 32'(irq), 32'd1);
    rd(3'd3, rv); chk("bot_width", rv, 32'd15);

    // WIDTH write on the boundary wins over the sweep step
    measure(1'b1, 99, 3'd3, 32'd22, w0, w1); chk("bwr_cur", 32'(w0), 32'd20);
    measure(1'b1, 50, 3'd2, 32'h0B, w0, w1); chk("bwr_next", 32'(w0), 32'd22);
    // Flag set at the boundary coinciding with a clear
    measure(1'b1, 99, 3'd2, 32'h0B, w0, w1); chk("bwr_cont", 32'(w0), 32'd27);
    rd(3'd2, rv); chk("setclr_ctrl", rv, 32'd15);
    rd(3'd3, rv); chk("setclr_width", rv, 32'd30);
    chk("setclr_irq", 32'(irq), 32'd1);

    // Disable mid-pulse: output drops at once, WIDTH and DIR held
    goto(3);
    chk("dis_pre", 32'(pwm_out[0]), 32'd1);
    wr(3'd2, 32'd0);
    chk("dis_now", 32'(pwm_out[0]), 32'd0);
    measure(1'b0, 0, 3'd0, 32'd0, w0, w1); chk("dis_period", 32'(w0), 32'd0);
    rd(3'd3, rv); chk("dis_width", rv, 32'd30);
    rd(3'd2, rv); chk("dis_ctrl", rv, 32'd12);

    // MIN > MAX forces WIDTH=MIN and keeps DIR
    wr(3'd0, 32'd40);
    wr(3'd2, 32'd1);
    measure(1'b0, 0, 3'd0, 32'd0, w0, w1); chk("inv_w0", 32'(w0), 32'd40);
    rd(3'd2, rv); chk("inv_ctrl", rv, 32'd13);

    // Reset mid-pulse
    goto(7);
    chk("mr_pre", 32'(pwm_out[0]), 32'd1);
    reset = 1'b1;
    cyc();
    chk("mr_pwm", 32'(pwm_out), 32'd0);
    chk("mr_irq", 32'(irq), 32'd0);
    chk("mr_rdata", avs_readdata, 32'd0);
    cyc();
    reset = 1'b0;
    rd(3'd4, rv); chk("mr_min1", rv, 32'd10);
    rd(3'd0, rv); chk("mr_min0", rv, 32'd10);
    rd(3'd1, rv); chk("mr_max0", rv, 32'd30);
    cyc();
    chk("rd_hold", avs_readdata, 32'd30);
    rd(3'd3, rv); chk("mr_width0", rv, 32'd10);
    rd(3'd2, rv); chk("mr_ctrl0", rv, 32'd0);
    chk("mr_irq2", 32'(irq), 32'd0);
    wr(3'd2, 32'd1);
    goto(9);
    chk("phase_hi", 32'(pwm_out[0]), 32'd1);
    cyc();
    chk("phase_lo", 32'(pwm_out[0]), 32'd0);
    measure(1'b0, 0, 3'd0, 32'd0, w0, w1); chk("mr_period", 32'(w0), 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
